// File: rtl/checker_pkg.sv
// Shared encodings and default bus constants for the memory-write self-check unit.
package checker_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_PASS = 2'd2,
        ST_FAIL = 2'd3
    } state_t;

    localparam logic [31:0] DEF_PASS_ADDR  = 32'd84;
    localparam logic [31:0] DEF_PASS_DATA  = 32'd7;
    localparam logic [31:0] DEF_ALLOW_ADDR = 32'd80;

    // A store ends the test successfully only with the exact address/data pair.
    function automatic logic is_pass_write(
        input logic        we,
        input logic [31:0] adr,
        input logic [31:0] dat,
        input logic [31:0] pass_adr,
        input logic [31:0] pass_dat
    );
        return we && (adr == pass_adr) && (dat == pass_dat);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear, count enable and optional saturation at all-ones.
module sat_counter #(
    parameter int W        = 16,
    parameter bit SATURATE = 1'b1
) (
    input  logic         i_clk,
    input  logic         i_clr,
    input  logic         i_en,
    output logic [W-1:0] o_count
);

    logic [W-1:0] r_count;
    logic         w_at_max;
    logic         w_step;

    assign w_at_max = (r_count == {W{1'b1}});
    assign w_step   = i_en && !(SATURATE && w_at_max);
    assign o_count  = r_count;

    // Clear dominates; otherwise advance unless pinned at the ceiling.
    always_ff @(posedge i_clk) begin
        if (i_clr) begin
            r_count <= '0;
        end else if (w_step) begin
            r_count <= r_count + W'(1);
        end else begin
            r_count <= r_count;
        end
    end

endmodule

// File: rtl/mem_write_checker.sv
// Watches the CPU data-memory store bus and decides pass/fail in hardware,
// with a RUN-cycle timeout and capture of the first offending store.
module mem_write_checker
    import checker_pkg::*;
#(
    parameter logic [31:0] PASS_ADDR      = DEF_PASS_ADDR,
    parameter logic [31:0] PASS_DATA      = DEF_PASS_DATA,
    parameter logic [31:0] ALLOW_ADDR     = DEF_ALLOW_ADDR,
    parameter int          TIMEOUT_CYCLES = 100000,
    parameter int          CNT_W          = 32
) (
    input  logic             clka,
    input  logic             rst,
    input  logic             memwrite,
    input  logic [31:0]      dataadr,
    input  logic [31:0]      writedata,
    input  logic [31:0]      pc,
    output logic [1:0]       state,
    output logic             pass,
    output logic             fail,
    output logic             timeout,
    output logic             done,
    output logic [15:0]      write_count,
    output logic [CNT_W-1:0] cycle_count,
    output logic [31:0]      fail_addr,
    output logic [31:0]      fail_data,
    output logic [31:0]      fail_pc
);

    state_t      r_state;
    logic        r_pass;
    logic        r_fail;
    logic        r_timeout;
    logic [31:0] r_fail_addr;
    logic [31:0] r_fail_data;
    logic [31:0] r_fail_pc;

    logic             w_in_run;
    logic             w_pass_hit;
    logic             w_bad_hit;
    logic             w_allow_hit;
    logic             w_timeout_edge;
    logic [CNT_W-1:0] w_cycle_count;

    assign w_in_run    = (r_state == ST_RUN);
    assign w_pass_hit  = is_pass_write(memwrite, dataadr, writedata, PASS_ADDR, PASS_DATA);
    // A wrong-data store to PASS_ADDR lands here too, since it is not ALLOW_ADDR.
    assign w_bad_hit   = memwrite && !w_pass_hit && (dataadr != ALLOW_ADDR);
    assign w_allow_hit = memwrite && !w_pass_hit && (dataadr == ALLOW_ADDR);
    // Counter still holds the pre-edge value, so this edge is the last allowed RUN cycle.
    assign w_timeout_edge = (w_cycle_count == CNT_W'(TIMEOUT_CYCLES - 1));

    sat_counter #(
        .W        (16),
        .SATURATE (1'b1)
    ) u_write_cnt (
        .i_clk   (clka),
        .i_clr   (rst),
        .i_en    (w_in_run && w_allow_hit),
        .o_count (write_count)
    );

    sat_counter #(
        .W        (CNT_W),
        .SATURATE (1'b0)
    ) u_cycle_cnt (
        .i_clk   (clka),
        .i_clr   (rst),
        .i_en    (w_in_run),
        .o_count (w_cycle_count)
    );

    // Check FSM: pass/bad-write take priority over the timeout edge; terminal states are sticky.
    always_ff @(posedge clka) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_pass      <= 1'b0;
            r_fail      <= 1'b0;
            r_timeout   <= 1'b0;
            r_fail_addr <= 32'd0;
            r_fail_data <= 32'd0;
            r_fail_pc   <= 32'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_state <= ST_RUN;
                end
                ST_RUN: begin
                    if (w_pass_hit) begin
                        r_state <= ST_PASS;
                        r_pass  <= 1'b1;
                    end else if (w_bad_hit) begin
                        r_state     <= ST_FAIL;
                        r_fail      <= 1'b1;
                        r_fail_addr <= dataadr;
                        r_fail_data <= writedata;
                        r_fail_pc   <= pc;
                    end else if (w_timeout_edge) begin
                        r_state   <= ST_FAIL;
                        r_fail    <= 1'b1;
                        r_timeout <= 1'b1;
                    end else begin
                        r_state <= ST_RUN;
                    end
                end
                ST_PASS: begin
                    r_state <= ST_PASS;
                end
                ST_FAIL: begin
                    r_state <= ST_FAIL;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign state       = r_state;
    assign pass        = r_pass;
    assign fail        = r_fail;
    assign timeout     = r_timeout;
    assign done        = r_pass | r_fail;
    assign cycle_count = w_cycle_count;
    assign fail_addr   = r_fail_addr;
    assign fail_data   = r_fail_data;
    assign fail_pc     = r_fail_pc;

endmodule

// File: tb/tb_mem_write_checker.sv
// Bench for mem_write_checker: directed scenarios plus randomized store traffic
// scored against a behavioural model of the pass/fail rule.
module tb_mem_write_checker;

    localparam int MAIN_TO  = 100000;
    localparam int SHORT_TO = 20;

    logic        clka;
    logic        rst;
    logic        rst_t;
    logic        memwrite;
    logic [31:0] dataadr;
    logic [31:0] writedata;
    logic [31:0] pc;

    logic [1:0]  state,   state_t;
    logic        pass,    pass_t;
    logic        fail,    fail_t;
    logic        timeout, timeout_t;
    logic        done,    done_t;
    logic [15:0] wc,      wc_t;
    logic [31:0] cc;
    logic [15:0] cc_t;
    logic [31:0] fa, fd, fp, fa_t, fd_t, fp_t;

    int total = 0;
    int bad   = 0;

    // behavioural model of the default-parameter instance
    int          m_st;
    bit          m_pass, m_fail, m_to;
    int unsigned m_wc, m_cc;
    logic [31:0] m_fa, m_fd, m_fp;

    mem_write_checker dut (
        .clka(clka), .rst(rst), .memwrite(memwrite), .dataadr(dataadr),
        .writedata(writedata), .pc(pc), .state(state), .pass(pass), .fail(fail),
        .timeout(timeout), .done(done), .write_count(wc), .cycle_count(cc),
        .fail_addr(fa), .fail_data(fd), .fail_pc(fp)
    );

    mem_write_checker #(.TIMEOUT_CYCLES(SHORT_TO), .CNT_W(16)) dut_t (
        .clka(clka), .rst(rst_t), .memwrite(memwrite), .dataadr(dataadr),
        .writedata(writedata), .pc(pc), .state(state_t), .pass(pass_t), .fail(fail_t),
        .timeout(timeout_t), .done(done_t), .write_count(wc_t), .cycle_count(cc_t),
        .fail_addr(fa_t), .fail_data(fd_t), .fail_pc(fp_t)
    );

    initial clka = 1'b0;
    always #5 clka = ~clka;

    task automatic model_update();
        if (rst) begin
            m_st = 0; m_pass = 0; m_fail = 0; m_to = 0;
            m_wc = 0; m_cc = 0; m_fa = 0; m_fd = 0; m_fp = 0;
        end else if (m_st == 0) begin
            m_st = 1;
        end else if (m_st == 1) begin
            m_cc++;
            if (memwrite && dataadr == 32'd84 && writedata == 32'd7) begin
                m_st = 2; m_pass = 1;
            end else if (memwrite && dataadr != 32'd80) begin
                m_st = 3; m_fail = 1;
                m_fa = dataadr; m_fd = writedata; m_fp = pc;
            end else begin
                if (memwrite && m_wc < 65535) m_wc++;
                if (m_cc == MAIN_TO) begin
                    m_st = 3; m_fail = 1; m_to = 1;
                end
            end
        end
    endtask

    task automatic tick(input logic mw, input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] p);
        memwrite = mw; dataadr = a; writedata = d; pc = p;
        @(posedge clka);
        model_update();
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 10; i++) tick(1'b0, 32'd0, 32'd0, 32'd0);
        total++;
        if ({state, pass, fail, timeout, done} !== 6'd0) begin
            bad++; $display("FAIL reset_flags got=%b exp=000000", {state, pass, fail, timeout, done});
        end
        total++;
        if ({wc, cc, fa, fd, fp} !== 144'd0) begin
            bad++; $display("FAIL reset_values got wc=%0h cc=%0h fa=%0h exp all 0", wc, cc, fa);
        end
        rst = 1'b0;
        tick(1'b1, 32'd100, 32'd0, 32'd0);
        total++;
        if (state !== 2'd1 || cc !== 32'd0 || fail !== 1'b0) begin
            bad++; $display("FAIL idle_to_run got state=%0d cc=%0d fail=%b exp 1 0 0", state, cc, fail);
        end
    endtask

    task automatic test_pass_sequence();
        rst = 1'b1;
        for (int i = 0; i < 10; i++) tick(1'b0, 32'd0, 32'd0, 32'd0);
        rst = 1'b0;
        tick(1'b0, 32'd0, 32'd0, 32'd0);
        tick(1'b1, 32'd80, 32'd1, 32'h10);
        tick(1'b1, 32'd80, 32'd2, 32'h14);
        total++;
        if (pass !== 1'b0 || wc !== 16'd2) begin
            bad++; $display("FAIL pre_pass got pass=%b wc=%0d exp 0 2", pass, wc);
        end
        tick(1'b1, 32'd84, 32'd7, 32'h18);
        total++;
        if (pass !== 1'b1 || fail !== 1'b0 || state !== 2'd2 || wc !== 16'd2 || done !== 1'b1) begin
            bad++; $display("FAIL pass_seq got pass=%b fail=%b state=%0d wc=%0d done=%b exp 1 0 2 2 1",
                            pass, fail, state, wc, done);
        end
    endtask

    task automatic test_sticky_and_midrun_reset();
        for (int i = 0; i < 3; i++) tick(1'b1, 32'd100, 32'd0, 32'h44);
        total++;
        if (pass !== 1'b1 || fail !== 1'b0 || state !== 2'd2 || wc !== 16'd2 ||
            cc !== 32'd3 || fa !== 32'd0) begin
            bad++; $display("FAIL sticky_pass got pass=%b fail=%b state=%0d wc=%0d cc=%0d exp 1 0 2 2 3",
                            pass, fail, state, wc, cc);
        end
        rst = 1'b1; tick(1'b0, 32'd0, 32'd0, 32'd0);
        rst = 1'b0; tick(1'b0, 32'd0, 32'd0, 32'd0);
        tick(1'b1, 32'd80, 32'd5, 32'h0);
        tick(1'b1, 32'd80, 32'd5, 32'h0);
        rst = 1'b1; tick(1'b1, 32'd84, 32'd7, 32'h0);
        total++;
        if (state !== 2'd0 || pass !== 1'b0 || wc !== 16'd0 || cc !== 32'd0) begin
            bad++; $display("FAIL midrun_reset got state=%0d pass=%b wc=%0d cc=%0d exp 0 0 0 0",
                            state, pass, wc, cc);
        end
        rst = 1'b0; tick(1'b0, 32'd0, 32'd0, 32'd0);
        tick(1'b0, 32'd0, 32'd0, 32'd0);
        total++;
        if (state !== 2'd1 || cc !== 32'd1) begin
            bad++; $display("FAIL restart_count got state=%0d cc=%0d exp 1 1", state, cc);
        end
    endtask

    task automatic test_bad_write();
        rst = 1'b1; tick(1'b0, 32'd0, 32'd0, 32'd0);
        rst = 1'b0; tick(1'b0, 32'd0, 32'd0, 32'd0);
        tick(1'b1, 32'd84, 32'd6, 32'h0000_0040);
        total++;
        if (fail !== 1'b1 || timeout !== 1'b0 || pass !== 1'b0 || state !== 2'd3 ||
            fa !== 32'd84 || fd !== 32'd6 || fp !== 32'h40) begin
            bad++; $display("FAIL bad_write got fail=%b to=%b state=%0d fa=%0d fd=%0d fp=%0h exp 1 0 3 84 6 40",
                            fail, timeout, state, fa, fd, fp);
        end
    endtask

    task automatic test_timeout();
        rst = 1'b1; rst_t = 1'b1;
        tick(1'b0, 32'd0, 32'd0, 32'd0);
        tick(1'b0, 32'd0, 32'd0, 32'd0);
        rst_t = 1'b0;
        tick(1'b0, 32'd0, 32'd0, 32'd0);
        for (int i = 0; i < SHORT_TO - 1; i++) tick(1'b0, 32'd84, 32'd7, 32'd0);
        total++;
        if (fail_t !== 1'b0 || state_t !== 2'd1 || cc_t !== 16'd19) begin
            bad++; $display("FAIL pre_timeout got fail=%b state=%0d cc=%0d exp 0 1 19", fail_t, state_t, cc_t);
        end
        tick(1'b0, 32'd0, 32'd0, 32'd0);
        total++;
        if (fail_t !== 1'b1 || timeout_t !== 1'b1 || state_t !== 2'd3 || cc_t !== 16'd20 ||
            fa_t !== 32'd0 || fd_t !== 32'd0 || fp_t !== 32'd0) begin
            bad++; $display("FAIL timeout got fail=%b to=%b state=%0d cc=%0d fa=%0h exp 1 1 3 20 0",
                            fail_t, timeout_t, state_t, cc_t, fa_t);
        end
        for (int i = 0; i < 3; i++) tick(1'b1, 32'd84, 32'd7, 32'd0);
        total++;
        if (cc_t !== 16'd20 || pass_t !== 1'b0 || done_t !== 1'b1) begin
            bad++; $display("FAIL timeout_frozen got cc=%0d pass=%b done=%b exp 20 0 1", cc_t, pass_t, done_t);
        end
    endtask

    task automatic test_timeout_pass();
        rst_t = 1'b1; tick(1'b0, 32'd0, 32'd0, 32'd0);
        rst_t = 1'b0; tick(1'b0, 32'd0, 32'd0, 32'd0);
        for (int i = 0; i < SHORT_TO - 1; i++) tick(1'b1, 32'd80, 32'd9, 32'd0);
        tick(1'b1, 32'd84, 32'd7, 32'h88);
        total++;
        if (pass_t !== 1'b1 || timeout_t !== 1'b0 || fail_t !== 1'b0 || state_t !== 2'd2 ||
            wc_t !== 16'd19) begin
            bad++; $display("FAIL timeout_pass got pass=%b to=%b fail=%b state=%0d wc=%0d exp 1 0 0 2 19",
                            pass_t, timeout_t, fail_t, state_t, wc_t);
        end
        rst_t = 1'b1;
    endtask

    task automatic test_random();
        logic        mw;
        logic [31:0] a, d;
        int          r;
        for (int ep = 0; ep < 10; ep++) begin
            rst = 1'b1; tick(1'b0, 32'd0, 32'd0, 32'd0);
            rst = 1'b0;
            for (int c = 0; c < 60; c++) begin
                mw = 1'($urandom_range(0, 1));
                r  = $urandom_range(0, 99);
                if (r < 85)      a = 32'd80;
                else if (r < 93) a = 32'd84;
                else             a = $urandom & 32'h0000_00FC;
                d = (a == 32'd84) ? 32'($urandom_range(6, 8)) : $urandom;
                tick(mw, a, d, $urandom);
                total++;
                if (state !== 2'(m_st) || pass !== m_pass || fail !== m_fail ||
                    timeout !== m_to || done !== (m_pass | m_fail)) begin
                    bad++; $display("FAIL rand_flags ep=%0d c=%0d got st=%0d p=%b f=%b t=%b exp st=%0d p=%b f=%b t=%b",
                                    ep, c, state, pass, fail, timeout, m_st, m_pass, m_fail, m_to);
                end
                total++;
                if (wc !== 16'(m_wc) || cc !== m_cc || fa !== m_fa || fd !== m_fd || fp !== m_fp) begin
                    bad++; $display("FAIL rand_values ep=%0d c=%0d got wc=%0d cc=%0d fa=%0h fd=%0h fp=%0h exp %0d %0d %0h %0h %0h",
                                    ep, c, wc, cc, fa, fd, fp, m_wc, m_cc, m_fa, m_fd, m_fp);
                end
            end
        end
    endtask

    task automatic test_saturate();
        rst = 1'b1; tick(1'b0, 32'd0, 32'd0, 32'd0);
        rst = 1'b0; tick(1'b0, 32'd0, 32'd0, 32'd0);
        for (int i = 0; i < 70000; i++) tick(1'b1, 32'd80, $urandom, 32'h20);
        total++;
        if (wc !== 16'hFFFF || fail !== 1'b0 || state !== 2'd1 || cc !== 32'd70000) begin
            bad++; $display("FAIL saturate got wc=%0h fail=%b state=%0d cc=%0d exp ffff 0 1 70000",
                            wc, fail, state, cc);
        end
    endtask

    initial begin
        rst = 1'b1; rst_t = 1'b1;
        memwrite = 1'b0; dataadr = 32'd0; writedata = 32'd0; pc = 32'd0;
        test_reset();
        test_pass_sequence();
        test_sticky_and_midrun_reset();
        test_bad_write();
        test_timeout();
        test_timeout_pass();
        test_random();
        test_saturate();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
